// File: rtl/serial_byte_assembler_pkg.sv
// Shared state encoding and parameter defaults for the serial byte assembler
// and the downstream capture-register bench.
package serial_byte_assembler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W     = 8;
  localparam bit          DEF_MSB_FIRST  = 1'b1;
  localparam bit          DEF_PARITY_EN  = 1'b1;
  localparam bit          DEF_PARITY_ODD = 1'b0;

endpackage

// File: rtl/serial_byte_assembler_sipo_shift_reg.sv
// Serial-in parallel-out shift register; clr_load starts a fresh word
// holding only bit_in in the position the first serial bit enters.
module sipo_shift_reg #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_load,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] shift_word;

  generate
    if (MSB_FIRST) begin : g_msb
      assign load_word  = {{(DATA_W-1){1'b0}}, bit_in};
      assign shift_word = {q[DATA_W-2:0], bit_in};
    end else begin : g_lsb
      assign load_word  = {bit_in, {(DATA_W-1){1'b0}}};
      assign shift_word = {bit_in, q[DATA_W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           q <= '0;
    else if (clr_load) q <= load_word;
    else if (shift_en) q <= shift_word;
  end

endmodule

// File: rtl/serial_byte_assembler.sv
// Frames qualified serial bits into DATA_W-bit words with optional trailing
// parity; the finished word is registered with a one-cycle data_valid strobe.
//
// state     | meaning
// ST_IDLE   | waiting for a bit_valid & sync_in to start a frame
// ST_SHIFT  | collecting data bits 1..DATA_W-1
// ST_PARITY | all data bits held, next valid bit is the parity bit
module serial_byte_assembler
  import serial_byte_assembler_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter bit          MSB_FIRST  = DEF_MSB_FIRST,
  parameter bit          PARITY_EN  = DEF_PARITY_EN,
  parameter bit          PARITY_ODD = DEF_PARITY_ODD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sync_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              busy
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              par_acc;
  logic              clr_load, shift_en, done_data, done_par;
  logic [DATA_W-1:0] q, word_nxt;

  sipo_shift_reg #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .clr_load (clr_load),
    .shift_en (shift_en),
    .bit_in   (bit_in),
    .q        (q)
  );

  // Without parity the word completes on the same edge as the last shift,
  // so the output register needs the post-shift value directly.
  generate
    if (MSB_FIRST) begin : g_msb
      assign word_nxt = {q[DATA_W-2:0], bit_in};
    end else begin : g_lsb
      assign word_nxt = {bit_in, q[DATA_W-1:1]};
    end
  endgenerate

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // sync_in is checked first so an abort/restart beats completion.
  always_comb begin
    state_nxt = state;
    clr_load  = 1'b0;
    shift_en  = 1'b0;
    done_data = 1'b0;
    done_par  = 1'b0;
    if (bit_valid) begin
      if (sync_in) begin
        clr_load  = 1'b1;
        state_nxt = ST_SHIFT;
      end else begin
        case (state)
          ST_SHIFT: begin
            shift_en = 1'b1;
            if (cnt == LAST_CNT) begin
              if (PARITY_EN) begin
                state_nxt = ST_PARITY;
              end else begin
                state_nxt = ST_IDLE;
                done_data = 1'b1;
              end
            end
          end
          ST_PARITY: begin
            done_par  = 1'b1;
            state_nxt = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      par_acc    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (clr_load)                  cnt <= CNT_W'(1);
      else if (done_data || done_par) cnt <= '0;
      else if (shift_en)             cnt <= cnt + 1'b1;

      if (clr_load)      par_acc <= bit_in;
      else if (shift_en) par_acc <= par_acc ^ bit_in;

      data_valid <= done_data | done_par;
      parity_err <= done_par & ((par_acc ^ bit_in) != PARITY_ODD);
      if (done_par)       data_out <= q;
      else if (done_data) data_out <= word_nxt;
    end
  end

endmodule

// File: tb/tb_serial_byte_assembler.sv
// Directed bench: three assembler instances (default, odd parity,
// LSB-first without parity) share one serial stimulus stream.
module tb_serial_byte_assembler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       sync_in = 1'b0;

  logic [7:0] data_a, data_o, data_l;
  logic       dv_a, dv_o, dv_l;
  logic       perr_a, perr_o, perr_l;
  logic       busy_a, busy_o, busy_l;

  int n_cmp = 0;
  int n_bad = 0;
  int str_a = 0;
  int str_l = 0;
  int nacc  = 0;
  int str_nacc [$];

  always #5 clk = ~clk;

  serial_byte_assembler dut_a (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sync_in(sync_in),
    .data_out(data_a), .data_valid(dv_a), .parity_err(perr_a), .busy(busy_a)
  );

  serial_byte_assembler #(.PARITY_ODD(1'b1)) dut_o (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sync_in(sync_in),
    .data_out(data_o), .data_valid(dv_o), .parity_err(perr_o), .busy(busy_o)
  );

  serial_byte_assembler #(.MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sync_in(sync_in),
    .data_out(data_l), .data_valid(dv_l), .parity_err(perr_l), .busy(busy_l)
  );

  always @(posedge clk) if (bit_valid && !rst) nacc++;

  always @(negedge clk) begin
    if (dv_a) begin
      str_a++;
      str_nacc.push_back(nacc);
    end
    if (dv_l) str_l++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs of the accepting edge are
  // visible when this returns.
  task automatic drive(input logic b, input logic v, input logic s);
    bit_in = b; bit_valid = v; sync_in = s;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Sends seq[n-1] first, sync on the first bit, gap idle cycles between bits.
  task automatic send_seq(input logic [15:0] seq, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i != 0) idle(gap);
      drive(seq[n-1-i], 1'b1, (i == 0));
    end
  endtask

  initial begin
    int sa, sl;
    logic [8:0] f34;

    #1;
    check_val("rst_data", {24'd0, data_a}, 32'h00);
    check_val("rst_dv",   {31'd0, dv_a}, 32'd0);
    check_val("rst_perr", {31'd0, perr_a}, 32'd0);
    check_val("rst_busy", {31'd0, busy_a}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle(1);

    // 1: A5 + even parity 0
    send_seq({7'd0, 8'hA5, 1'b0}, 9, 0);
    check_val("t1_dv",     {31'd0, dv_a}, 32'd1);
    check_val("t1_data",   {24'd0, data_a}, 32'hA5);
    check_val("t1_perr",   {31'd0, perr_a}, 32'd0);
    check_val("t1_odd_err", {31'd0, perr_o}, 32'd1);
    check_val("t1_lsb_data", {24'd0, data_l}, 32'hA5);
    idle(1);
    check_val("t1_dv_drop", {31'd0, dv_a}, 32'd0);
    check_val("t1_strobes", str_a, 1);

    // 2: parity bit 1
    send_seq({7'd0, 8'hA5, 1'b1}, 9, 0);
    check_val("t2_data",    {24'd0, data_a}, 32'hA5);
    check_val("t2_perr",    {31'd0, perr_a}, 32'd1);
    check_val("t2_odd_perr", {31'd0, perr_o}, 32'd0);
    check_val("t2_odd_dv",  {31'd0, dv_o}, 32'd1);
    idle(1);

    // 3: LSB-first, no parity, then same frame with 3-cycle gaps
    sl = str_l;
    send_seq({8'd0, 8'h80}, 8, 0);
    check_val("t3_lsb_dv",   {31'd0, dv_l}, 32'd1);
    check_val("t3_lsb_data", {24'd0, data_l}, 32'h01);
    check_val("t3_lsb_perr", {31'd0, perr_l}, 32'd0);
    idle(1);
    send_seq({8'd0, 8'h80}, 8, 3);
    check_val("t3_gap_data", {24'd0, data_l}, 32'h01);
    idle(1);
    check_val("t3_strobes", str_l - sl, 2);
    check_val("t3_busy", {31'd0, busy_l}, 32'd0);

    // 4: abort after 4 bits, restart with 3C
    sa = str_a;
    send_seq({12'd0, 4'b1011}, 4, 0);
    send_seq({7'd0, 8'h3C, 1'b0}, 9, 0);
    check_val("t4_data", {24'd0, data_a}, 32'h3C);
    check_val("t4_perr", {31'd0, perr_a}, 32'd0);
    idle(1);
    check_val("t4_strobes", str_a - sa, 1);

    // 5: reset mid-frame
    sa = str_a;
    send_seq({11'd0, 5'b10110}, 5, 0);
    check_val("t5_busy_mid", {31'd0, busy_a}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("t5_rst_data", {24'd0, data_a}, 32'h00);
    check_val("t5_rst_dv",   {31'd0, dv_a}, 32'd0);
    check_val("t5_rst_perr", {31'd0, perr_a}, 32'd0);
    check_val("t5_rst_busy", {31'd0, busy_a}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle(2);
    check_val("t5_no_strobe", str_a - sa, 0);
    send_seq({7'd0, 8'hFF, 1'b0}, 9, 0);
    check_val("t5_data", {24'd0, data_a}, 32'hFF);
    check_val("t5_perr", {31'd0, perr_a}, 32'd0);
    idle(1);

    // 6: unsynced bits ignored, then back-to-back 12 / 34
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    check_val("t6_idle_busy", {31'd0, busy_a}, 32'd0);
    check_val("t6_idle_data", {24'd0, data_a}, 32'hFF);
    sa = str_a;
    str_nacc.delete();
    send_seq({7'd0, 8'h12, 1'b0}, 9, 0);
    check_val("t6_first_dv",   {31'd0, dv_a}, 32'd1);
    check_val("t6_first_data", {24'd0, data_a}, 32'h12);
    f34 = {8'h34, 1'b1};
    for (int i = 0; i < 9; i++) begin
      drive(f34[8-i], 1'b1, (i == 0));
      check_val("t6_hold", {24'd0, data_a}, (i == 8) ? 32'h34 : 32'h12);
    end
    check_val("t6_second_dv", {31'd0, dv_a}, 32'd1);
    check_val("t6_second_perr", {31'd0, perr_a}, 32'd0);
    idle(1);
    check_val("t6_strobes", str_a - sa, 2);
    if (str_nacc.size() == 2)
      check_val("t6_spacing", str_nacc[1] - str_nacc[0], 9);
    else
      check_val("t6_strobe_log", str_nacc.size(), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
